// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin sharing of one pipelined cordic core among NREQ requesters.
// Define CORDIC_ARB_FIXED_PRIO_EN for strict fixed priority (lowest index wins) instead of round-robin.
module cordic_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 17,
  parameter int LAT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ*W-1:0] req_theta,
  output logic [W-1:0]      cx_i,
  output logic [W-1:0]      cy_i,
  output logic [W-1:0]      ctheta_i,
  input  logic [W-1:0]      cx_o,
  input  logic [W-1:0]      cy_o,
  input  logic [W-1:0]      ctheta_o,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_x,
  output logic [W-1:0]      rsp_y,
  output logic [W-1:0]      rsp_theta,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic          found;
  logic [IW-1:0] gidx;
  logic [LAT:0]  tag_vld;
  logic [IW-1:0] tag_idx [0:LAT];

`ifdef CORDIC_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        gidx  = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr;

  // Search starts at ptr and wraps, so the last winner is searched last.
  always_comb begin
    int j;
    found = 1'b0;
    gidx  = '0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        gidx  = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (found && rst) req_ready[gidx] = 1'b1;
  end

  // Idle cycles load zero so the core never sees stale operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx_i     <= '0;
      cy_i     <= '0;
      ctheta_i <= '0;
    end else if (found) begin
      cx_i     <= req_x[int'(gidx)*W +: W];
      cy_i     <= req_y[int'(gidx)*W +: W];
      ctheta_i <= req_theta[int'(gidx)*W +: W];
    end else begin
      cx_i     <= '0;
      cy_i     <= '0;
      ctheta_i <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int i = 0; i <= LAT; i++) tag_idx[i] <= '0;
    end else begin
      tag_vld    <= {tag_vld[LAT-1:0], found};
      tag_idx[0] <= gidx;
      for (int i = 1; i <= LAT; i++) tag_idx[i] <= tag_idx[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_x     <= '0;
      rsp_y     <= '0;
      rsp_theta <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_vld[LAT]) begin
        rsp_valid[tag_idx[LAT]] <= 1'b1;
        rsp_x                   <= cx_o;
        rsp_y                   <= cy_o;
        rsp_theta               <= ctheta_o;
      end
    end
  end

  assign busy = (|tag_vld) || (|rsp_valid);

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one pipelined cordic rotation core between NREQ requesters.
- Round-robin arbitration admits at most one operation (x, y, theta) per cycle and registers the operands onto the core inputs.
- A tag pipeline, matched to the core latency, routes each result back to the requester that issued it.
- Sits between the motion/kinematics requesters and the single cordic instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 17, operand/result width, matching cordic x/y/theta.
- LAT, 16, cordic core latency in clocks, from operand registered at x_i/y_i/theta_i to result valid on x_o/y_o/theta_o.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_x  in  NREQ*W  packed x operands; requester k in bits [k*W +: W].
- req_y  in  NREQ*W  packed y operands.
- req_theta  in  NREQ*W  packed theta operands.
- cx_i, cy_i, ctheta_i  out  W each  registered operands to cordic.
- cx_o, cy_o, ctheta_o  in  W each  cordic results.
- rsp_valid  out  NREQ  one-hot, one-cycle result strobe.
- rsp_x, rsp_y, rsp_theta  out  W each  registered result, shared by all requesters.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Handshake:
  - An operation transfers on a rising edge when req_valid[k] && req_ready[k].
  - req_ready is combinational from req_valid and the arbitration pointer.
  - req_ready is forced to 0 while rst is low.
  - Requesters hold valid and operands stable until accepted.
  - No response backpressure: a requester must sink rsp_valid whenever it is asserted.
- Arbitration:
  - Round-robin pointer ptr, range 0..NREQ-1, reset to 0.
  - Grant goes to the first valid requester searching ptr, ptr+1, … modulo NREQ.
  - On grant to k, ptr becomes (k+1) mod NREQ. With no grant, ptr holds.
- Operand stage:
  - On accept, cx_i/cy_i/ctheta_i register the granted operands.
  - In idle cycles they register 0, so the core always sees deterministic input.
- Tag pipeline:
  - Depth LAT+1, each entry {vld, idx[clog2(NREQ)-1:0]}.
  - Stage 0 is loaded alongside the operand registers.
  - When the entry exits the pipe, cx_o/cy_o/ctheta_o are registered into rsp_x/rsp_y/rsp_theta, and rsp_valid[idx] is set for one cycle.
- Latency:
  - Accept edge at cycle 0 gives rsp_valid high during cycle LAT+2, exactly one cycle.
  - Throughput is 1 operation per clock aggregate.
- Results:
  - rsp_x/rsp_y/rsp_theta hold their last value when rsp_valid is 0.
  - Results are not sign-manipulated; widths pass through unchanged.
- busy: OR of all tag-pipeline vld bits plus the rsp_valid stage.
- Reset values (all asynchronous on rst low): rsp_valid=0, rsp_* =0, c*_i=0, all tag vld=0, ptr=0, busy=0.
- Boundary conditions:
  - All NREQ requesters valid continuously: grants rotate 0,1,2,3,0,…; no requester is starved, and each waits at most NREQ-1 cycles.
  - Single requester valid continuously: it is granted every cycle, giving back-to-back results on consecutive cycles.
  - Requester drops valid before grant: nothing is issued for it.
  - Reset asserted mid-flight: all in-flight operations are discarded, no rsp_valid is produced for them, and the core inputs go to 0 immediately.

Optional Feature:
- Macro: CORDIC_ARB_FIXED_PRIO_EN.
- Defined: strict fixed priority. Lowest index wins; ptr is removed; a continuously valid requester 0 starves all others.
- Undefined: round-robin as above.
- Latency, tag routing and reset behaviour are identical in both builds.

Test Plan:
- Bench uses a cordic stub that delays {x,y,theta} by LAT, echoing operands unchanged.
- Single request: requester 1 issues x=1, y=0, theta=0 at cycle 0 -> req_ready[1]=1 in cycle 0; rsp_valid=4'b0010 in cycle LAT+2 with rsp_x=1, rsp_y=0, rsp_theta=0; busy falls the following cycle.
- All four valid for 8 cycles, operands x=k+16*n -> grant order 0,1,2,3,0,1,2,3; responses return in the same order, each with matching x, 1 per cycle.
- Back-to-back on requester 2, x=10,11,12 on consecutive cycles -> three consecutive rsp_valid=4'b0100 strobes carrying 10, 11, 12.
- Pointer fairness: requesters 0 and 3 always valid, ptr=0 after reset -> grants alternate 0,3,0,3.
- With CORDIC_ARB_FIXED_PRIO_EN, the same stimulus -> only requester 0 is granted.
- Reset mid-flight: issue 3 operations, pull rst low at cycle 5 for 2 cycles -> no rsp_valid afterwards, busy=0, cx_i=0 during reset; a new request after release returns normally at LAT+2.
